// File: rtl/decode_issue_pkg.sv
// rtl/decode_issue_pkg.sv - shared widths, opcode codes, RV32 field constants and decoder for decode_issue
package decode_issue_pkg;

  localparam int DSIZE = 32;
  localparam int ISIZE = 32;
  localparam int NREG  = 32;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_MUL  = 4'd1,
    OP_ADDI = 4'd2,
    OP_LW   = 4'd3,
    OP_SW   = 4'd4,
    OP_BNE  = 4'd5,
    OP_NOP  = 4'd15
  } op_e;

  localparam logic [6:0] RV_OP     = 7'b0110011;
  localparam logic [6:0] RV_OPIMM  = 7'b0010011;
  localparam logic [6:0] RV_LOAD   = 7'b0000011;
  localparam logic [6:0] RV_STORE  = 7'b0100011;
  localparam logic [6:0] RV_BRANCH = 7'b1100011;
  localparam logic [2:0] F3_ADD    = 3'b000;
  localparam logic [2:0] F3_WORD   = 3'b010;
  localparam logic [2:0] F3_BNE    = 3'b001;
  localparam logic [6:0] F7_ADD    = 7'b0000000;
  localparam logic [6:0] F7_MUL    = 7'b0000001;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_e;

  typedef struct packed {
    op_e              code;
    logic             legal;
    logic             use_rs2;
    logic             wen;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [DSIZE-1:0] imm;
  } dec_t;

  // rd is only reported for instructions that really write it; rd==x0 suppresses the write.
  function automatic dec_t decode(input logic [ISIZE-1:0] w);
    dec_t d;
    d      = '0;
    d.code = OP_NOP;
    d.rs1  = w[19:15];
    d.rs2  = w[24:20];
    case (w[6:0])
      RV_OP: begin
        if (w[14:12] == F3_ADD && w[31:25] == F7_ADD) begin
          d.code = OP_ADD; d.legal = 1'b1; d.use_rs2 = 1'b1; d.wen = 1'b1;
        end else if (w[14:12] == F3_ADD && w[31:25] == F7_MUL) begin
          d.code = OP_MUL; d.legal = 1'b1; d.use_rs2 = 1'b1; d.wen = 1'b1;
        end
      end
      RV_OPIMM: begin
        if (w[14:12] == F3_ADD) begin
          d.code = OP_ADDI; d.legal = 1'b1; d.wen = 1'b1;
          d.imm  = {{(DSIZE-12){w[31]}}, w[31:20]};
        end
      end
      RV_LOAD: begin
        if (w[14:12] == F3_WORD) begin
          d.code = OP_LW; d.legal = 1'b1; d.wen = 1'b1;
          d.imm  = {{(DSIZE-12){w[31]}}, w[31:20]};
        end
      end
      RV_STORE: begin
        if (w[14:12] == F3_WORD) begin
          d.code = OP_SW; d.legal = 1'b1; d.use_rs2 = 1'b1;
          d.imm  = {{(DSIZE-12){w[31]}}, w[31:25], w[11:7]};
        end
      end
      RV_BRANCH: begin
        if (w[14:12] == F3_BNE) begin
          d.code = OP_BNE; d.legal = 1'b1; d.use_rs2 = 1'b1;
          d.imm  = {{(DSIZE-13){w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
        end
      end
      default: ;
    endcase
    if (d.wen) d.rd = w[11:7];
    if (d.rd == 5'd0) d.wen = 1'b0;
    return d;
  endfunction

endpackage

// File: rtl/decode_issue_regfile.sv
// rtl/decode_issue_regfile.sv - 32-entry register file, two write-first bypassed read ports, x0 reads zero
module decode_issue_regfile
  import decode_issue_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [4:0]       wr_addr,
  input  logic [DSIZE-1:0] wr_data,
  input  logic [4:0]       rd_addr0,
  input  logic [4:0]       rd_addr1,
  output logic [DSIZE-1:0] rd_data0,
  output logic [DSIZE-1:0] rd_data1
);

  logic [DSIZE-1:0] mem_q [NREG];
  logic [DSIZE-1:0] mem_d [NREG];
  logic             wr_live;

  assign wr_live = wr_en && (wr_addr != 5'd0);

  always_comb begin
    mem_d = mem_q;
    if (wr_live) mem_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) mem_q <= '{default: '0};
    else      mem_q <= mem_d;
  end

  // Same-cycle writeback is visible to the reader so a resolving load feeds its consumer directly.
  always_comb begin
    rd_data0 = '0;
    rd_data1 = '0;
    if (rd_addr0 != 5'd0) rd_data0 = (wr_live && wr_addr == rd_addr0) ? wr_data : mem_q[rd_addr0];
    if (rd_addr1 != 5'd0) rd_data1 = (wr_live && wr_addr == rd_addr1) ? wr_data : mem_q[rd_addr1];
  end

endmodule

// File: rtl/decode_issue.sv
// rtl/decode_issue.sv - decode/issue stage with single-outstanding-load scoreboard and RUN/STALL control
module decode_issue
  import decode_issue_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [ISIZE-1:0] in_instr,
  output logic             in_ready,
  input  logic             flush,
  input  logic             wb_en,
  input  logic [4:0]       wb_rd,
  input  logic [DSIZE-1:0] wb_data,
  output logic [3:0]       instr_code,
  output logic [DSIZE-1:0] a,
  output logic [DSIZE-1:0] b,
  output logic [DSIZE-1:0] imm,
  output logic [4:0]       out_rd,
  output logic             out_wen,
  output logic             out_valid,
  output logic             illegal
);

  state_e           state_q, state_d;
  logic [ISIZE-1:0] hold_q, hold_d;
  logic             pend_valid_q, pend_valid_d;
  logic [4:0]       pend_rd_q, pend_rd_d;
  op_e              code_q, code_d;
  logic [DSIZE-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d;
  logic [4:0]       rd_q, rd_d;
  logic             wen_q, wen_d, valid_q, valid_d, illegal_q, illegal_d;

  logic [ISIZE-1:0] cur_word;
  dec_t             dec;
  logic [DSIZE-1:0] rs1_val, rs2_val;
  logic             accept, clearing, hazard, take, go, capture;

  // In STALL the decoder looks at the held word, so hazard re-evaluation needs no extra state.
  assign cur_word = (state_q == ST_STALL) ? hold_q : in_instr;
  assign dec      = decode(cur_word);

  decode_issue_regfile u_regfile (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wb_en),
    .wr_addr  (wb_rd),
    .wr_data  (wb_data),
    .rd_addr0 (dec.rs1),
    .rd_addr1 (dec.rs2),
    .rd_data0 (rs1_val),
    .rd_data1 (rs2_val)
  );

  assign clearing = pend_valid_q && wb_en && (wb_rd == pend_rd_q);
  assign hazard   = dec.legal && pend_valid_q && !clearing &&
                    ((dec.rs1 == pend_rd_q) || (dec.use_rs2 && dec.rs2 == pend_rd_q) ||
                     (dec.code == OP_LW));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_RUN;
      hold_q       <= '0;
      pend_valid_q <= 1'b0;
      pend_rd_q    <= '0;
      code_q       <= OP_NOP;
      a_q          <= '0;
      b_q          <= '0;
      imm_q        <= '0;
      rd_q         <= '0;
      wen_q        <= 1'b0;
      valid_q      <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      pend_valid_q <= pend_valid_d;
      pend_rd_q    <= pend_rd_d;
      code_q       <= code_d;
      a_q          <= a_d;
      b_q          <= b_d;
      imm_q        <= imm_d;
      rd_q         <= rd_d;
      wen_q        <= wen_d;
      valid_q      <= valid_d;
      illegal_q    <= illegal_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) state_d = ST_RUN;
    else begin
      case (state_q)
        ST_RUN:   if (accept && hazard) state_d = ST_STALL;
        ST_STALL: if (!hazard) state_d = ST_RUN;
        default:  state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    in_ready  = rst && (state_q == ST_RUN) && !flush;
    accept    = in_valid && in_ready;
    take      = (state_q == ST_RUN) ? accept : !flush;
    go        = take && !hazard;
    capture   = (state_q == ST_RUN) && accept && hazard;

    hold_d    = flush ? '0 : (capture ? in_instr : hold_q);
    code_d    = OP_NOP;
    a_d       = a_q;
    b_d       = b_q;
    imm_d     = imm_q;
    rd_d      = rd_q;
    wen_d     = 1'b0;
    valid_d   = 1'b0;
    illegal_d = 1'b0;
    if (go && dec.legal) begin
      code_d  = dec.code;
      a_d     = rs1_val;
      b_d     = dec.use_rs2 ? rs2_val : '0;
      imm_d   = dec.imm;
      rd_d    = dec.rd;
      wen_d   = dec.wen;
      valid_d = 1'b1;
    end else if (go) begin
      illegal_d = 1'b1;
    end

    // A newly issued load outranks a same-cycle clear of the previous one.
    pend_valid_d = pend_valid_q;
    pend_rd_d    = pend_rd_q;
    if (go && dec.legal && dec.code == OP_LW && dec.wen) begin
      pend_valid_d = 1'b1;
      pend_rd_d    = dec.rd;
    end else if (clearing) begin
      pend_valid_d = 1'b0;
    end
  end

  assign instr_code = code_q;
  assign a          = a_q;
  assign b          = b_q;
  assign imm        = imm_q;
  assign out_rd     = rd_q;
  assign out_wen    = wen_q;
  assign out_valid  = valid_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_decode_issue.sv
// tb/tb_decode_issue.sv - table-driven scoreboard bench for decode_issue
module tb_decode_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic [3:0]  instr_code;
  logic [31:0] a, b, imm;
  logic [4:0]  out_rd;
  logic        out_wen, out_valid, illegal;

  always #5 clk = ~clk;

  decode_issue dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_instr   (in_instr),
    .in_ready   (in_ready),
    .flush      (flush),
    .wb_en      (wb_en),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .instr_code (instr_code),
    .a          (a),
    .b          (b),
    .imm        (imm),
    .out_rd     (out_rd),
    .out_wen    (out_wen),
    .out_valid  (out_valid),
    .illegal    (illegal)
  );

  typedef struct packed {
    logic [3:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        wen;
    logic        ov;
    logic        ill;
  } out_t;

  typedef struct {
    logic        rstn;
    logic        vld;
    logic [31:0] instr;
    logic        fl;
    logic        we;
    logic [4:0]  wrd;
    logic [31:0] wdat;
    logic        rdy;
    out_t        exp;
  } vec_t;

  vec_t vt[$];
  out_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void v(input logic rstn, input logic vld, input logic [31:0] instr,
                            input logic fl, input logic we, input logic [4:0] wrd,
                            input logic [31:0] wdat, input logic rdy,
                            input logic [3:0] code, input logic [31:0] ea, input logic [31:0] eb,
                            input logic [31:0] eimm, input logic [4:0] erd,
                            input logic ewen, input logic eov, input logic eill);
    vec_t r;
    r.rstn = rstn; r.vld = vld; r.instr = instr; r.fl = fl;
    r.we = we; r.wrd = wrd; r.wdat = wdat; r.rdy = rdy;
    r.exp = '{code: code, a: ea, b: eb, imm: eimm, rd: erd, wen: ewen, ov: eov, ill: eill};
    vt.push_back(r);
  endfunction

  out_t got, want;

  initial begin
    //  rstn vld instr         fl we wrd wdat    rdy  code a      b  imm           rd wen ov ill
    v(0, 0, 32'h0,         0, 0, 0, 0,      0,  15, 0,     0, 0,            0, 0, 0, 0);
    v(1, 1, 32'h00500093,  0, 0, 0, 0,      1,   2, 0,     0, 5,            1, 1, 1, 0);
    v(1, 0, 32'h0,         0, 1, 1, 5,      1,  15, 0,     0, 5,            1, 0, 0, 0);
    v(1, 0, 32'h0,         0, 1, 2, 7,      1,  15, 0,     0, 5,            1, 0, 0, 0);
    v(1, 1, 32'h002081B3,  0, 0, 0, 0,      1,   0, 5,     7, 0,            3, 1, 1, 0);
    v(1, 1, 32'h002081B3,  0, 1, 2, 9,      1,   0, 5,     9, 0,            3, 1, 1, 0);
    // load-use stall, resolved by a same-cycle writeback of x4
    v(1, 1, 32'h0080A203,  0, 0, 0, 0,      1,   3, 5,     0, 8,            4, 1, 1, 0);
    v(1, 1, 32'h001202B3,  0, 0, 0, 0,      1,  15, 5,     0, 8,            4, 0, 0, 0);
    v(1, 0, 32'h0,         0, 0, 0, 0,      0,  15, 5,     0, 8,            4, 0, 0, 0);
    v(1, 0, 32'h0,         0, 1, 4, 32'h11, 0,   0, 32'h11, 5, 0,           5, 1, 1, 0);
    v(1, 1, 32'hFE209EE3,  0, 0, 0, 0,      1,   5, 5,     9, 32'hFFFFFFFC, 0, 0, 1, 0);
    v(1, 1, 32'h00000000,  0, 0, 0, 0,      1,  15, 5,     9, 32'hFFFFFFFC, 0, 0, 0, 1);
    v(1, 0, 32'h0,         0, 0, 0, 0,      1,  15, 5,     9, 32'hFFFFFFFC, 0, 0, 0, 0);
    // flush during STALL keeps the scoreboard
    v(1, 1, 32'h0080A203,  0, 0, 0, 0,      1,   3, 5,     0, 8,            4, 1, 1, 0);
    v(1, 1, 32'h001202B3,  0, 0, 0, 0,      1,  15, 5,     0, 8,            4, 0, 0, 0);
    v(1, 0, 32'h0,         1, 0, 0, 0,      0,  15, 5,     0, 8,            4, 0, 0, 0);
    v(1, 1, 32'h00500093,  0, 0, 0, 0,      1,   2, 0,     0, 5,            1, 1, 1, 0);
    v(1, 1, 32'h001202B3,  0, 0, 0, 0,      1,  15, 0,     0, 5,            1, 0, 0, 0);
    // reset mid-STALL, then the x4 reader issues without stalling
    v(0, 0, 32'h0,         0, 0, 0, 0,      0,  15, 0,     0, 0,            0, 0, 0, 0);
    v(1, 1, 32'h001202B3,  0, 0, 0, 0,      1,   0, 0,     0, 0,            5, 1, 1, 0);
    v(1, 1, 32'h021081B3,  0, 1, 1, 3,      1,   1, 3,     3, 0,            3, 1, 1, 0);
    v(1, 1, 32'hFE102FA3,  0, 0, 0, 0,      1,   4, 0,     3, 32'hFFFFFFFF, 0, 0, 1, 0);
    v(1, 1, 32'h80008013,  0, 0, 0, 0,      1,   2, 3,     0, 32'hFFFFF800, 0, 0, 1, 0);
    v(1, 0, 32'h0,         0, 0, 0, 0,      1,  15, 3,     0, 32'hFFFFF800, 0, 0, 0, 0);
    // flush in RUN refuses the offered word
    v(1, 1, 32'h00500093,  1, 0, 0, 0,      0,  15, 3,     0, 32'hFFFFF800, 0, 0, 0, 0);
    v(1, 0, 32'h0,         0, 0, 0, 0,      1,  15, 3,     0, 32'hFFFFF800, 0, 0, 0, 0);

    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      rst      = vt[i].rstn;
      in_valid = vt[i].vld;
      in_instr = vt[i].instr;
      flush    = vt[i].fl;
      wb_en    = vt[i].we;
      wb_rd    = vt[i].wrd;
      wb_data  = vt[i].wdat;
      sb.push_back(vt[i].exp);
      #1;
      n_cmp++;
      if (in_ready !== vt[i].rdy) begin
        n_bad++;
        $display("FAIL row%0d in_ready: got %0b want %0b", i, in_ready, vt[i].rdy);
      end
      @(posedge clk);
      #1;
      got  = '{code: instr_code, a: a, b: b, imm: imm, rd: out_rd,
               wen: out_wen, ov: out_valid, ill: illegal};
      want = sb.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL row%0d bundle: got code=%0d a=%h b=%h imm=%h rd=%0d wen=%0b valid=%0b ill=%0b want code=%0d a=%h b=%h imm=%h rd=%0d wen=%0b valid=%0b ill=%0b",
                 i, got.code, got.a, got.b, got.imm, got.rd, got.wen, got.ov, got.ill,
                 want.code, want.a, want.b, want.imm, want.rd, want.wen, want.ov, want.ill);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/decode_issue.md
Name: decode_issue

Overview:
Decode/issue stage that produces the operand bundle consumed by the ALU stage: instr_code, a, b, imm, plus destination-register tags.
- Accepts 32-bit RV32 instructions from fetch via a valid/ready handshake.
- Decodes the supported subset ADD, MUL, ADDI, LW, SW and BNE.
- Reads the internal register file and registers the bundle for the ALU.
- Enforces a single-outstanding-load scoreboard that stalls load-use hazards until writeback arrives.

Parameters:
DSIZE, 32, data/operand width (equals the shared `DSIZE).
ISIZE, 32, instruction width.
NREG, 32, architectural registers; x0 hardwired to zero.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-low reset (0 = reset)
in_valid  input  1  fetch presents an instruction
in_instr  input  ISIZE  instruction word
in_ready  output  1  block accepts in_instr this cycle
flush  input  1  branch-resolution kill of the issue stage
wb_en  input  1  writeback strobe
wb_rd  input  5  writeback register index
wb_data  input  DSIZE  writeback value
instr_code  output  4  ALU opcode
a  output  DSIZE  rs1 value
b  output  DSIZE  rs2 value
imm  output  DSIZE  sign-extended immediate
out_rd  output  5  destination register of the issued instruction
out_wen  output  1  issued instruction writes rd (ADD, MUL, ADDI, LW with rd≠0)
out_valid  output  1  bundle is a real instruction, not a bubble
illegal  output  1  one-cycle pulse: accepted word was unsupported

Behaviour:
- Opcode codes: ADD=0, MUL=1, ADDI=2, LW=3, SW=4, BNE=5, NOP=15.
- Decode rules:
  - ADD: op 0110011, f3 000, f7 0000000.
  - MUL: op 0110011, f3 000, f7 0000001.
  - ADDI: op 0010011, f3 000.
  - LW: op 0000011, f3 010.
  - SW: op 0100011, f3 010.
  - BNE: op 1100011, f3 001.
  - Anything else: issue NOP with out_valid=0, pulse illegal.
- Immediates, sign-extended to DSIZE:
  - I-type (ADDI, LW): instr[31:20].
  - S-type (SW): {instr[31:25], instr[11:7]}.
  - B-type (BNE): {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - Immediate is 0 for ADD and MUL.
- b is driven with the rs2 value for ADD, MUL, SW and BNE, and with 0 otherwise.
- Latency: an accepted instruction appears on the registered outputs after the next rising edge. With no accept, outputs become a NOP bubble (instr_code=15, out_valid=0, out_wen=0, a/b/imm hold).
- Register file: 32×DSIZE.
  - Written when wb_en=1 and wb_rd≠0; writes to x0 are ignored.
  - Read is combinational with write-first bypass: a read of wb_rd in the same cycle returns wb_data.
- Scoreboard (pend_valid, pend_rd):
  - Set when an LW with rd≠0 issues.
  - Cleared when wb_en=1 and wb_rd==pend_rd; a same-cycle clear counts as resolved.
- Hazard: pend_valid and not clearing this cycle, and either:
  - the decoded instruction reads pend_rd (rs1 always; rs2 for ADD/MUL/SW/BNE), or
  - the instruction is itself LW (single outstanding load).
- FSM states RUN and STALL:
  - in_ready = rst & (state==RUN) & ~flush.
  - RUN, valid & no hazard: issue the instruction.
  - RUN, valid & hazard: capture the word into the hold register, issue a bubble, go to STALL.
  - STALL: in_ready=0; bubbles each cycle. When the hazard clears (evaluated on the held word), issue the held instruction with bypassed operands and return to RUN.
- flush=1 has highest priority:
  - next-cycle outputs are a bubble, the held word is dropped, state goes to RUN, and in_valid is not accepted.
  - The scoreboard is retained, because the load is still in flight.
- Reset (rst=0), also mid-STALL:
  - state=RUN, hold and scoreboard cleared, all registers 0.
  - instr_code=15, a=b=imm=0, out_rd=0, out_wen=0, out_valid=0, illegal=0, in_ready=0.

Decomposition:
- Shared define file holds:
  - DSIZE, ISIZE;
  - the opcode codes (ADD, MUL, ADDI, LW, SW, BNE, NOP);
  - RV32 major-opcode/funct constants;
  - FSM state codes RUN=0, STALL=1.
- One sub-module, regfile: 32×DSIZE, two combinational read ports with write bypass, one write port, synchronous active-low clear.

Test Plan:
- Issue 0x00500093 (ADDI x1,x0,5) -> next cycle instr_code=2, a=0, imm=5, out_rd=1, out_wen=1, out_valid=1.
- Write x1=5 and x2=7 via wb, then issue 0x002081B3 (ADD x3,x1,x2) -> instr_code=0, a=5, b=7, imm=0; repeat with wb of x2=9 in the same cycle -> b=9 (bypass).
- Issue 0x0080A203 (LW x4,8(x1)), then 0x001202B3 (ADD x5,x4,x1) -> bubbles with in_ready=0 until wb_en with wb_rd=4 and wb_data=0x11 arrives; then ADD issues with a=0x11 in that cycle's bundle.
- Issue 0xFE209EE3 (BNE x1,x2,-4) -> instr_code=5, imm=0xFFFFFFFC; issue 0x00000000 -> illegal pulses 1 cycle, out_valid=0, instr_code=15.
- During STALL, assert flush -> held word dropped, state RUN, next instruction accepted; scoreboard still blocks a read of x4.
- Drive rst=0 mid-STALL for one cycle -> all outputs at reset values, in_ready=0; after release, in_ready=1 and reading x4 issues without a stall.
